// File: rtl/boolean_preimage_pkg.sv
// Shared types and fixed function tables for the boolean preimage finder.
// Optional feature macro used by the top: BOOLEAN_PREIMAGE_MASK_EN.
package boolean_preimage_pkg;

   localparam int unsigned CODE_W  = 4;
   localparam int unsigned COUNT_W = 5;
   localparam int unsigned TABLE_W = 16;

   // Bit n of each table is the function value for input code n.
   localparam logic [TABLE_W-1:0] F1_TABLE = 16'h35A5;
   localparam logic [TABLE_W-1:0] F2_TABLE = 16'hEEE2;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   function automatic logic [TABLE_W-1:0] select_mask(input logic sel, input logic target);
      logic [TABLE_W-1:0] t;
      t = sel ? F2_TABLE : F1_TABLE;
      return target ? t : ~t;
   endfunction

   // True when no mask bit above idx is set, i.e. idx is the final match.
   function automatic logic is_last_match(input logic [TABLE_W-1:0] mask,
                                          input logic [CODE_W-1:0] idx);
      logic [TABLE_W-1:0] hi;
      hi = mask >> idx;
      return hi[TABLE_W-1:1] == '0;
   endfunction

endpackage

// File: rtl/boolean_preimage_beat_reg.sv
// Single-entry valid/ready output register carrying a match code and last flag.
module boolean_preimage_beat_reg
   import boolean_preimage_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [CODE_W-1:0] load_code,
   input  logic              load_last,
   input  logic              ready,
   output logic              valid,
   output logic [CODE_W-1:0] code,
   output logic              last
);

   logic              valid_q;
   logic [CODE_W-1:0] code_q;
   logic              last_q;

   // The caller never asserts load while a held beat is stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         code_q  <= '0;
         last_q  <= 1'b0;
      end else if (load) begin
         valid_q <= 1'b1;
         code_q  <= load_code;
         last_q  <= load_last;
      end else if (ready) begin
         valid_q <= 1'b0;
      end
   end

   assign valid = valid_q;
   assign code  = code_q;
   assign last  = last_q;

endmodule

// File: rtl/boolean_preimage_finder.sv
// Enumerates all 4-bit codes driving F1/F2 to a target value, streamed in ascending order.
// Define BOOLEAN_PREIMAGE_MASK_EN to add the done_mask output.
module boolean_preimage_finder
   import boolean_preimage_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_sel,
   input  logic               req_target,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CODE_W-1:0]  out_code,
   output logic               out_last,
   output logic               done,
   output logic [COUNT_W-1:0] done_count
`ifdef BOOLEAN_PREIMAGE_MASK_EN
   ,
   output logic [TABLE_W-1:0] done_mask
`endif
);

   state_t               state_q;
   logic [CODE_W-1:0]    idx_q;
   logic [TABLE_W-1:0]   mask_q;
   logic [COUNT_W-1:0]   count_q;
   logic                 done_q;
`ifdef BOOLEAN_PREIMAGE_MASK_EN
   logic [TABLE_W-1:0]   done_mask_q;
`endif

   logic                 accept;
   logic                 stall;
   logic                 xfer;
   logic                 eval;
   logic                 hit;
   logic                 hit_last;
   logic [TABLE_W-1:0]   req_mask;

   assign req_ready = (state_q == IDLE);
   assign accept    = req_valid & req_ready;
   assign stall     = out_valid & ~out_ready;
   assign xfer      = out_valid & out_ready;
   assign eval      = (state_q == SCAN) & ~stall;
   assign hit       = mask_q[idx_q];
   assign hit_last  = is_last_match(mask_q, idx_q);
   assign req_mask  = select_mask(req_sel, req_target);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         mask_q  <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
`ifdef BOOLEAN_PREIMAGE_MASK_EN
         done_mask_q <= '0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef BOOLEAN_PREIMAGE_MASK_EN
         done_mask_q <= '0;
`endif
         if (xfer) begin
            count_q <= count_q + COUNT_W'(1);
         end
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  mask_q  <= req_mask;
                  idx_q   <= '0;
                  count_q <= '0;
                  if (req_mask == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
`ifdef BOOLEAN_PREIMAGE_MASK_EN
                     done_mask_q <= req_mask;
`endif
                  end else begin
                     state_q <= SCAN;
                  end
               end
            end
            SCAN: begin
               if (eval) begin
                  idx_q <= idx_q + CODE_W'(1);
                  // Leave as soon as the final match is loaded; nothing past it is scanned.
                  if (hit && hit_last) begin
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (xfer) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
`ifdef BOOLEAN_PREIMAGE_MASK_EN
                  done_mask_q <= mask_q;
`endif
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign done       = done_q;
   assign done_count = count_q;
`ifdef BOOLEAN_PREIMAGE_MASK_EN
   assign done_mask  = done_mask_q;
`endif

   boolean_preimage_beat_reg u_beat_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (eval & hit),
      .load_code (idx_q),
      .load_last (hit_last),
      .ready     (out_ready),
      .valid     (out_valid),
      .code      (out_code),
      .last      (out_last)
   );

endmodule

// File: tb/tb_boolean_preimage_finder.sv
// Directed, table-driven bench for boolean_preimage_finder with cycle-exact beat timing checks.
module tb_boolean_preimage_finder;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_sel;
   logic        req_target;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_code;
   logic        out_last;
   logic        done;
   logic [4:0]  done_count;
`ifdef BOOLEAN_PREIMAGE_MASK_EN
   logic [15:0] done_mask;
`endif

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        sel;
      logic        tgt;
      logic [15:0] mask;
      int          cnt;
   } vec_t;

   vec_t vecs [4];

   boolean_preimage_finder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_sel    (req_sel),
      .req_target (req_target),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_code   (out_code),
      .out_last   (out_last),
      .done       (done),
      .done_count (done_count)
`ifdef BOOLEAN_PREIMAGE_MASK_EN
      ,
      .done_mask  (done_mask)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic start(input logic sel, input logic tgt, input bit hold);
      @(negedge clk);
      check($sformatf("idle before req sel%0d t%0d", sel, tgt), 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_sel    = sel;
      req_target = tgt;
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
   endtask

   // Cycle-exact run with out_ready high: beat for code k at T+2+k, done at T+3+last.
   task automatic run_timed(input logic sel, input logic tgt, input logic [15:0] m,
                            input int cnt);
      int last_k;
      logic [7:0] act, exp;
      logic [3:0] kc;
      logic ev;
      last_k = 0;
      for (int i = 0; i < 16; i++) if (m[i]) last_k = i;
      out_ready = 1'b1;
      start(sel, tgt, 1'b0);
      for (int n = 1; n <= last_k + 3; n++) begin
         int k;
         @(negedge clk);
         k  = n - 2;
         ev = (k >= 0 && k <= last_k) ? m[k] : 1'b0;
         kc = k[3:0];
         exp = {1'b0, ev, ev ? kc : 4'd0, ev && (k == last_k), n == last_k + 3};
         act = {req_ready, out_valid, out_valid ? out_code : 4'd0, out_valid & out_last, done};
         check($sformatf("timed sel%0d t%0d cycle T+%0d", sel, tgt, n), 32'(act), 32'(exp));
         if (n == last_k + 3)
            check($sformatf("count sel%0d t%0d", sel, tgt), 32'(done_count), 32'(cnt));
`ifdef BOOLEAN_PREIMAGE_MASK_EN
         check($sformatf("done_mask sel%0d t%0d T+%0d", sel, tgt, n), 32'(done_mask),
               (n == last_k + 3) ? 32'(m) : 32'd0);
`endif
      end
      @(negedge clk);
      check($sformatf("back to idle sel%0d t%0d", sel, tgt), 32'({req_ready, done}), 32'b10);
   endtask

   // Follows transfers until done; expects codes from_k upward in mask order.
   task automatic collect(input string nm, input logic [15:0] m, input int cnt,
                          input int from_k, input int already);
      int ptr;
      int got;
      int rdy_err;
      bit seen_done;
      logic [15:0] hi;
      ptr = from_k;
      got = already;
      rdy_err = 0;
      seen_done = 1'b0;
      for (int c = 0; c < 60 && !seen_done; c++) begin
         @(negedge clk);
         if (req_ready) rdy_err++;
         if (out_valid && out_ready) begin
            while (ptr < 15 && !m[ptr]) ptr++;
            hi = m >> ptr;
            check($sformatf("%s beat %0d", nm, got), 32'({out_code, out_last}),
                  32'({ptr[3:0], hi[15:1] == 15'd0}));
            ptr++;
            got++;
         end
         if (done) begin
            seen_done = 1'b1;
            check($sformatf("%s done_count", nm), 32'(done_count), 32'(cnt));
            check($sformatf("%s beats seen", nm), 32'(got), 32'(cnt));
         end
      end
      check($sformatf("%s done reached", nm), 32'(seen_done), 32'd1);
      check($sformatf("%s req_ready low while busy", nm), 32'(rdy_err), 32'd0);
   endtask

   initial begin
      vecs[0] = '{sel: 1'b0, tgt: 1'b1, mask: 16'h35A5, cnt: 8};
      vecs[1] = '{sel: 1'b1, tgt: 1'b0, mask: 16'h111D, cnt: 6};
      vecs[2] = '{sel: 1'b1, tgt: 1'b1, mask: 16'hEEE2, cnt: 10};
      vecs[3] = '{sel: 1'b0, tgt: 1'b0, mask: 16'hCA5A, cnt: 8};

      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_sel    = 1'b0;
      req_target = 1'b0;
      out_ready  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset values", 32'({req_ready, out_valid, out_code, out_last, done, done_count}),
            32'({1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0}));
      rst_n = 1'b1;

      for (int v = 0; v < 4; v++) run_timed(vecs[v].sel, vecs[v].tgt, vecs[v].mask, vecs[v].cnt);

      // Backpressure: code 1 held for 5 cycles, then the stream resumes.
      begin
         bit found;
         found = 1'b0;
         out_ready = 1'b0;
         start(1'b1, 1'b1, 1'b0);
         for (int c = 0; c < 6 && !found; c++) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
         end
         check("stall first beat present", 32'(found), 32'd1);
         for (int i = 0; i < 5; i++) begin
            check($sformatf("stall hold cycle %0d", i), 32'({out_valid, out_code, out_last, done}),
                  32'({1'b1, 4'd1, 1'b0, 1'b0}));
            if (i < 4) @(negedge clk);
         end
         out_ready = 1'b1;
         collect("stall resume", 16'hEEE2, 10, 2, 1);
      end

      // Back-to-back: second request held during the first scan, accepted after done.
      start(1'b0, 1'b1, 1'b1);
      req_target = 1'b0;
      collect("b2b first", 16'h35A5, 8, 0, 0);
      @(negedge clk);
      check("b2b second accepted after done", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      collect("b2b second", 16'hCA5A, 8, 0, 0);

      // Reset while draining the final beat.
      begin
         bit found;
         int done_seen;
         found = 1'b0;
         done_seen = 0;
         out_ready = 1'b1;
         start(1'b1, 1'b1, 1'b0);
         for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk);
            if (out_valid && out_last) found = 1'b1;
         end
         check("drain last beat reached", 32'(found), 32'd1);
         out_ready = 1'b0;
         repeat (2) begin
            @(negedge clk);
            check("drain hold", 32'({out_valid, out_code, out_last, done}),
                  32'({1'b1, 4'd15, 1'b1, 1'b0}));
         end
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         check("after drain reset", 32'({out_valid, req_ready, done, done_count}),
               32'({1'b0, 1'b1, 1'b0, 5'd0}));
         out_ready = 1'b1;
         repeat (4) begin
            @(negedge clk);
            if (done) done_seen++;
         end
         check("no done after reset", 32'(done_seen), 32'd0);
      end

      run_timed(vecs[1].sel, vecs[1].tgt, vecs[1].mask, vecs[1].cnt);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
